cycle_sequencer: RTL and testbench

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cpu_timing_pkg.sv | 14 +
 rtl/cycle_sequencer_if.sv | 17 +
 rtl/opcode_field_decoder.sv | 9 +
 rtl/cycle_sequencer.sv | 54 +++++
 tb/tb_cycle_sequencer.sv | 103 ++++++++++
 5 files changed

// File: rtl/cpu_timing_pkg.sv
// cpu_timing_pkg: shared T-state/M-cycle widths, one-hot reset constants and NOP opcode
package cpu_timing_pkg;
  localparam int STEP_W = 4;
  localparam int COUNT_W = 8;
  localparam logic [STEP_W-1:0] STEP_RST = 4'b0001;
  localparam logic [COUNT_W-1:0] COUNT_RST = 8'b0000_0001;
  localparam logic [7:0] NOP_OP = 8'h00;
  typedef enum logic [STEP_W-1:0] {
    T1 = 4'b0001,
    T2 = 4'b0010,
    T3 = 4'b0100,
    T4 = 4'b1000
  } step_t;
endpackage

// File: rtl/cycle_sequencer_if.sv
// cycle_sequencer_if: sequencer control inputs (i_Hold, i_IR_Fetch, i_Bus_Data) and timing/decode outputs
interface cycle_sequencer_if;
  import cpu_timing_pkg::*;
  logic               i_Hold;
  logic               i_IR_Fetch;
  logic [7:0]         i_Bus_Data;
  logic [STEP_W-1:0]  o_Cycle_Step;
  logic [COUNT_W-1:0] o_Cycle_Count;
  logic [7:0]         o_Opcode;
  logic [3:0]         o_P;
  logic [1:0]         o_Q;
  logic               o_Fault;
  modport master (output i_Hold, i_IR_Fetch, i_Bus_Data,
                  input  o_Cycle_Step, o_Cycle_Count, o_Opcode, o_P, o_Q, o_Fault);
  modport slave  (input  i_Hold, i_IR_Fetch, i_Bus_Data,
                  output o_Cycle_Step, o_Cycle_Count, o_Opcode, o_P, o_Q, o_Fault);
endinterface

// File: rtl/opcode_field_decoder.sv
// opcode_field_decoder: one-hot P (opcode[5:4]) and Q (opcode[3]) field decode; in i_Opcode, out o_P, o_Q
module opcode_field_decoder (
  input  logic [7:0] i_Opcode,
  output logic [3:0] o_P,
  output logic [1:0] o_Q
);
  assign o_P = 4'b0001 << i_Opcode[5:4];
  assign o_Q = i_Opcode[3] ? 2'b10 : 2'b01;
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: T-state/M-cycle sequencer with opcode latch; ports i_Clk, i_Reset, bus (slave: hold/fetch/data in, step/count/opcode/P/Q/fault out); CYCLE_OVERRUN_TRAP_EN enables the overrun trap
module cycle_sequencer
  import cpu_timing_pkg::*;
(
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  cycle_sequencer_if.slave      bus
);
  step_t               r_step, w_step_nxt;
  logic [COUNT_W-1:0]  r_count, w_count_nxt;
  logic [7:0]          r_opcode, w_opcode_nxt;
  logic                w_boundary;
  assign w_boundary = !bus.i_Hold && r_step == T4;
`ifdef CYCLE_OVERRUN_TRAP_EN
  logic r_fault;
  logic w_overrun;
  assign w_overrun = w_boundary && !bus.i_IR_Fetch && r_count[COUNT_W-1];
  always_ff @(posedge i_Clk)
    if (i_Reset) r_fault <= 1'b0;
    else r_fault <= w_overrun;
  assign bus.o_Fault = r_fault;
`else
  assign bus.o_Fault = 1'b0;
`endif
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      r_step   <= T1;
      r_count  <= COUNT_RST;
      r_opcode <= NOP_OP;
    end else begin
      r_step   <= w_step_nxt;
      r_count  <= w_count_nxt;
      r_opcode <= w_opcode_nxt;
    end
  // Count restarts on a fetch and also wraps out of the top bit, so it never goes all-zero.
  always_comb begin
    w_step_nxt   = bus.i_Hold ? r_step : step_t'({r_step[STEP_W-2:0], r_step[STEP_W-1]});
    w_count_nxt  = !w_boundary ? r_count :
                   (bus.i_IR_Fetch || r_count[COUNT_W-1]) ? COUNT_RST : r_count << 1;
`ifdef CYCLE_OVERRUN_TRAP_EN
    w_opcode_nxt = (w_boundary && bus.i_IR_Fetch) ? bus.i_Bus_Data : w_overrun ? NOP_OP : r_opcode;
`else
    w_opcode_nxt = (w_boundary && bus.i_IR_Fetch) ? bus.i_Bus_Data : r_opcode;
`endif
  end
  assign bus.o_Cycle_Step  = r_step;
  assign bus.o_Cycle_Count = r_count;
  assign bus.o_Opcode      = r_opcode;
  opcode_field_decoder u_dec (
    .i_Opcode (r_opcode),
    .o_P      (bus.o_P),
    .o_Q      (bus.o_Q)
  );
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: scoreboard bench for cycle_sequencer with directed stimulus
module tb_cycle_sequencer;
  typedef struct packed {
    logic [3:0] step;
    logic [7:0] count;
    logic [7:0] op;
    logic [3:0] p;
    logic [1:0] q;
    logic       fault;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [3:0] m_step;
  logic [7:0] m_count;
  logic [7:0] m_op;
  logic       m_fault;
  cycle_sequencer_if bus ();
  cycle_sequencer dut (.i_Clk(clk), .i_Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e, a;
      e = sb.pop_front();
      a = {bus.o_Cycle_Step, bus.o_Cycle_Count, bus.o_Opcode, bus.o_P, bus.o_Q, bus.o_Fault};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t step/count/op/p/q/fault got %b/%h/%h/%b/%b/%b want %b/%h/%h/%b/%b/%b",
                 $time, a.step, a.count, a.op, a.p, a.q, a.fault,
                 e.step, e.count, e.op, e.p, e.q, e.fault);
      end
    end
  end
  task automatic tick(input logic r, input logic h, input logic f, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.i_Hold = h;
    bus.i_IR_Fetch = f;
    bus.i_Bus_Data = d;
    if (r) begin
      m_step = 4'b0001; m_count = 8'h01; m_op = 8'h00; m_fault = 1'b0;
    end else if (h) begin
      m_fault = 1'b0;
    end else begin
      m_fault = 1'b0;
      if (m_step == 4'b1000) begin
        if (f) begin
          m_op = d; m_count = 8'h01;
        end else if (m_count == 8'h80) begin
          m_count = 8'h01;
`ifdef CYCLE_OVERRUN_TRAP_EN
          m_op = 8'h00; m_fault = 1'b1;
`endif
        end else m_count = m_count << 1;
      end
      m_step = {m_step[2:0], m_step[3]};
    end
    e.step = m_step; e.count = m_count; e.op = m_op; e.fault = m_fault;
    e.p = 4'b0001 << m_op[5:4];
    e.q = m_op[3] ? 2'b10 : 2'b01;
    sb.push_back(e);
  endtask
  initial begin
    bus.i_Hold = 1'b0; bus.i_IR_Fetch = 1'b0; bus.i_Bus_Data = 8'h00;
    tick(1, 0, 0, 8'h00);
    tick(1, 1, 1, 8'hFF);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 8'h55);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 8'hEE);
    tick(0, 0, 1, 8'h12);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 8'h3A);
    tick(0, 0, 1, 8'h3A);
    for (int i = 0; i < 32; i++) tick(0, 0, 0, 8'hC7);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    tick(1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) tick(0, 0, i == 3, 8'h28);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00);
    tick(0, 1, 1, 8'h10);
    tick(0, 0, 1, 8'h30);
    tick(0, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
